// File: rtl/ntt_coeff_loader.sv
// Coefficient load transmitter for the NTT/INTT core: packs host beats into even/odd pairs,
// strobes them into the core, kicks start and waits for done. Optional CANON_REDUCE_EN reduces inputs mod Q.
module ntt_coeff_loader #(
    parameter int N  = 256,
    parameter int DW = 16,
    parameter int Q  = 3329,
    localparam int PW = (N / 2 > 1) ? $clog2(N / 2) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          cfg_mode,
    input  logic          abort,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          we,
    output logic [DW-1:0] data_ina,
    output logic [DW-1:0] data_inb,
    output logic          mode,
    output logic          start,
    input  logic          core_done,
    output logic          busy,
    output logic          job_done,
    output logic [PW-1:0] pair_cnt
);

    // state | meaning
    // IDLE  | no job; waits for go
    // FILL  | accepting coefficients, writing pairs to the core
    // KICK  | final pair written; pulse start next
    // RUN   | core running; waits for core_done
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        KICK = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [PW-1:0] LAST_PAIR = PW'(N / 2 - 1);

    state_t        state;
    logic [DW-1:0] hold;
    logic          half;
    logic [DW-1:0] coef;

`ifdef CANON_REDUCE_EN
    // Host guarantees x < 2Q, so one conditional subtract yields the canonical residue.
    assign coef = (s_data >= DW'(Q)) ? s_data - DW'(Q) : s_data;
`else
    logic unused_q;
    assign unused_q = ^DW'(Q);
    assign coef     = s_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            we       <= 1'b0;
            start    <= 1'b0;
            busy     <= 1'b0;
            job_done <= 1'b0;
            data_ina <= '0;
            data_inb <= '0;
            mode     <= 1'b0;
            pair_cnt <= '0;
            hold     <= '0;
            half     <= 1'b0;
        end else begin
            we       <= 1'b0;
            start    <= 1'b0;
            job_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= FILL;
                        mode     <= cfg_mode;
                        pair_cnt <= '0;
                        half     <= 1'b0;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (abort) begin
                        state   <= IDLE;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        half    <= 1'b0;
                    end else if (s_valid && s_ready) begin
                        if (!half) begin
                            hold <= coef;
                            half <= 1'b1;
                        end else begin
                            we       <= 1'b1;
                            data_ina <= hold;
                            data_inb <= coef;
                            half     <= 1'b0;
                            // Final count stays at N/2-1 so it fits the counter width.
                            if (pair_cnt == LAST_PAIR) begin
                                state   <= KICK;
                                s_ready <= 1'b0;
                            end else begin
                                pair_cnt <= pair_cnt + 1'b1;
                            end
                        end
                    end
                end
                KICK: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        start <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (core_done) begin
                        job_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Scoreboard bench for ntt_coeff_loader: expected pairs queued by the driver,
// popped and compared by a negedge monitor on every we strobe.
module tb_ntt_coeff_loader;

    localparam int N  = 256;
    localparam int DW = 16;
    localparam int Q  = 3329;
    localparam int PW = $clog2(N / 2);

    logic          clk;
    logic          rst;
    logic          go;
    logic          cfg_mode;
    logic          abort;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          we;
    logic [DW-1:0] data_ina;
    logic [DW-1:0] data_inb;
    logic          mode;
    logic          start;
    logic          core_done;
    logic          busy;
    logic          job_done;
    logic [PW-1:0] pair_cnt;

    ntt_coeff_loader #(.N(N), .DW(DW), .Q(Q)) dut (
        .clk(clk), .rst(rst), .go(go), .cfg_mode(cfg_mode), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .we(we), .data_ina(data_ina), .data_inb(data_inb), .mode(mode),
        .start(start), .core_done(core_done), .busy(busy), .job_done(job_done),
        .pair_cnt(pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          m;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_p;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    start_cnt = 0;
    int    done_cnt = 0;
    logic  prev_we = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_pair(input int a, input int b, input logic m);
        pair_t p;
        p.a = DW'(a);
        p.b = DW'(b);
        p.m = m;
        exp_q.push_back(p);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                check("we_not_back_to_back", {31'd0, prev_we}, 0);
                check("exp_q_nonempty", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    mon_p = exp_q.pop_front();
                    check("data_ina", {16'd0, data_ina}, {16'd0, mon_p.a});
                    check("data_inb", {16'd0, data_inb}, {16'd0, mon_p.b});
                    check("mode", {31'd0, mode}, {31'd0, mon_p.m});
                end
            end
            if (start) begin
                start_cnt++;
                check("start_after_final_we", {31'd0, prev_we}, 1);
            end
            if (job_done) done_cnt++;
            prev_we = we;
        end
    end

    task automatic send(input int v);
        int t = 0;
        s_valid = 1'b1;
        s_data  = DW'(v);
        while (!s_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("send_timeout", {31'd0, s_ready}, 1);
        else @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic go_job(input logic m);
        go       = 1'b1;
        cfg_mode = m;
        @(negedge clk);
        go = 1'b0;
        check("go_busy", {31'd0, busy}, 1);
        check("go_s_ready", {31'd0, s_ready}, 1);
        check("go_mode", {31'd0, mode}, {31'd0, m});
        check("go_pair_cnt", {25'd0, pair_cnt}, 0);
    endtask

    task automatic finish_job(input int dly, input bit poke_go);
        int t = 0;
        while (!start && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", {31'd0, start}, 1);
        check("final_pair_cnt", {25'd0, pair_cnt}, N / 2 - 1);
        check("run_s_ready", {31'd0, s_ready}, 0);
        if (poke_go) begin
            go       = 1'b1;
            cfg_mode = ~mode;
            @(negedge clk);
            go = 1'b0;
            check("run_go_busy", {31'd0, busy}, 1);
            check("run_go_s_ready", {31'd0, s_ready}, 0);
            check("run_go_pair_cnt", {25'd0, pair_cnt}, N / 2 - 1);
        end
        repeat (dly - 1) @(negedge clk);
        check("pre_done_busy", {31'd0, busy}, 1);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("job_done_pulse", {31'd0, job_done}, 1);
        check("busy_after_done", {31'd0, busy}, 0);
        @(negedge clk);
        check("job_done_single", {31'd0, job_done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int sc;
        int dc;
        rst = 1'b1; go = 1'b0; cfg_mode = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 0);
        check("rst_we", {31'd0, we}, 0);
        check("rst_start", {31'd0, start}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_job_done", {31'd0, job_done}, 0);
        check("rst_ina", {16'd0, data_ina}, 0);
        check("rst_inb", {16'd0, data_inb}, 0);
        check("rst_mode", {31'd0, mode}, 0);
        check("rst_pair_cnt", {25'd0, pair_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1 + T3: back-to-back full job in NTT mode, core_done 10 cycles after start
        go_job(1'b0);
        for (int k = 0; k < N / 2; k++) push_pair(2 * k, 2 * k + 1, 1'b0);
        c0 = cyc;
        for (int i = 0; i < N; i++) send(i);
        check("t1_throughput_cycles", cyc - c0, N);
        finish_job(10, 1'b0);

        // T2: random host gaps in INTT mode
        go_job(1'b1);
        for (int k = 0; k < N / 2; k++) push_pair(300 + 2 * k, 301 + 2 * k, 1'b1);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            send(300 + i);
        end
        finish_job(3, 1'b0);

        // T4: abort after 37 pairs, beat offered in the abort cycle is dropped
        sc = start_cnt;
        dc = done_cnt;
        go_job(1'b0);
        for (int k = 0; k < 37; k++) push_pair(2 * k, 2 * k + 1, 1'b0);
        for (int i = 0; i < 74; i++) send(i);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'd74;
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_s_ready", {31'd0, s_ready}, 0);
        check("abort_we", {31'd0, we}, 0);
        repeat (3) @(negedge clk);
        check("abort_no_start", start_cnt, sc);
        check("abort_no_job_done", done_cnt, dc);
        check("abort_q_drained", exp_q.size(), 0);
        go_job(1'b0);
        push_pair(500, 501, 1'b0);
        send(500);
        send(501);
        check("resume_pair_cnt", {25'd0, pair_cnt}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // T5: core_done during FILL and go during RUN are ignored
        go_job(1'b0);
        for (int k = 0; k < N / 2; k++) push_pair(1000 + 2 * k, 1001 + 2 * k, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i == 50) begin
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                check("fill_done_busy", {31'd0, busy}, 1);
                check("fill_done_s_ready", {31'd0, s_ready}, 1);
                check("fill_done_no_job_done", {31'd0, job_done}, 0);
            end
            send(1000 + i);
        end
        finish_job(5, 1'b1);

        // T6: canonical reduction of out-of-range inputs (pass-through in default build)
        go_job(1'b0);
`ifdef CANON_REDUCE_EN
        push_pair(0, 1, 1'b0);
        push_pair(3328, 5, 1'b0);
`else
        push_pair(3329, 3330, 1'b0);
        push_pair(6657, 5, 1'b0);
`endif
        send(3329);
        send(3330);
        send(6657);
        send(5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);

        check("end_q_empty", exp_q.size(), 0);
        check("total_start_pulses", start_cnt, 3);
        check("total_job_done_pulses", done_cnt, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
